// File: rtl/alu_sequencer.sv
// Multicycle control FSM sequencing the register-file/shifter/ALU datapath for one
// decoded command. Optional retired-command counter enabled by ALU_SEQ_PERF_EN.
module alu_sequencer #(
    parameter int CMD_W = 3,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [CMD_W-1:0] cmd,
    input  logic [2:0]       rd,
    input  logic [2:0]       rn,
    input  logic [2:0]       rm,
    input  logic [1:0]       shift,
    input  logic [IMM_W-1:0] imm,
    output logic [2:0]       rf_readnum,
    output logic [2:0]       rf_writenum,
    output logic             rf_write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             vsel,
    output logic [1:0]       alu_op,
    output logic [1:0]       shift_out,
    output logic [15:0]      imm16,
    output logic             done,
    output logic             err
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]      perf_retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [CMD_W-1:0] CMD_ADD  = CMD_W'(3'd0);
    localparam logic [CMD_W-1:0] CMD_CMP  = CMD_W'(3'd1);
    localparam logic [CMD_W-1:0] CMD_AND  = CMD_W'(3'd2);
    localparam logic [CMD_W-1:0] CMD_MVN  = CMD_W'(3'd3);
    localparam logic [CMD_W-1:0] CMD_MOVR = CMD_W'(3'd4);
    localparam logic [CMD_W-1:0] CMD_MOVI = CMD_W'(3'd5);

    function automatic logic [15:0] imm_ext(input logic [IMM_W-1:0] value);
        return 16'($signed(value));
    endfunction

    state_t           state_r, state_s;
    logic [CMD_W-1:0] cmd_r, cmd_s;
    logic [2:0]       rd_r, rd_s, rn_r, rn_s, rm_r, rm_s;
    logic [1:0]       shift_r, shift_s;
    logic [IMM_W-1:0] imm_r, imm_s;
    logic             accept_s;

    // Outputs are computed from the next state so they can be registered while
    // still reflecting the current state (Moore) in every cycle.
    logic        ready_r, ready_s;
    logic [2:0]  readnum_r, readnum_s, writenum_r, writenum_s;
    logic        rf_write_r, rf_write_s, loada_r, loada_s, loadb_r, loadb_s;
    logic        loadc_r, loadc_s, loads_r, loads_s, asel_r, asel_s, vsel_r, vsel_s;
    logic [1:0]  alu_op_r, alu_op_s, shift_out_r, shift_out_s;
    logic [15:0] imm16_r;
    logic        done_r, done_s, err_r, err_s;

    assign accept_s = instr_valid && (state_r == S_IDLE);

    // Field capture on accept; fields hold for the rest of the command.
    always_comb begin
        cmd_s   = cmd_r;
        rd_s    = rd_r;
        rn_s    = rn_r;
        rm_s    = rm_r;
        shift_s = shift_r;
        imm_s   = imm_r;
        if (accept_s) begin
            cmd_s   = cmd;
            rd_s    = rd;
            rn_s    = rn;
            rm_s    = rm;
            shift_s = shift;
            imm_s   = imm;
        end else begin
            cmd_s   = cmd_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    case (cmd)
                        CMD_ADD, CMD_CMP, CMD_AND: state_s = S_GET_A;
                        CMD_MVN, CMD_MOVR:         state_s = S_GET_B;
                        CMD_MOVI:                  state_s = S_WRITE;
                        default:                   state_s = S_ERR;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_GET_A: state_s = S_GET_B;
            S_GET_B: state_s = S_EXEC;
            S_EXEC: begin
                if (cmd_r == CMD_CMP) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WRITE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Strobe decode for the state about to be entered.
    always_comb begin
        ready_s     = 1'b0;
        readnum_s   = 3'd0;
        writenum_s  = 3'd0;
        rf_write_s  = 1'b0;
        loada_s     = 1'b0;
        loadb_s     = 1'b0;
        loadc_s     = 1'b0;
        loads_s     = 1'b0;
        asel_s      = 1'b0;
        vsel_s      = 1'b0;
        alu_op_s    = 2'b00;
        shift_out_s = 2'b00;
        done_s      = 1'b0;
        err_s       = 1'b0;
        case (state_s)
            S_IDLE: ready_s = 1'b1;
            S_GET_A: begin
                readnum_s = rn_s;
                loada_s   = 1'b1;
            end
            S_GET_B: begin
                readnum_s = rm_s;
                loadb_s   = 1'b1;
            end
            S_EXEC: begin
                shift_out_s = shift_s;
                if (cmd_s == CMD_CMP) begin
                    alu_op_s = 2'b01;
                    loads_s  = 1'b1;
                    done_s   = 1'b1;
                end else begin
                    loadc_s = 1'b1;
                    case (cmd_s)
                        CMD_AND:  alu_op_s = 2'b10;
                        CMD_MVN:  alu_op_s = 2'b11;
                        CMD_MOVR: asel_s   = 1'b1;
                        default:  alu_op_s = 2'b00;
                    endcase
                end
            end
            S_WRITE: begin
                writenum_s = rd_s;
                rf_write_s = 1'b1;
                done_s     = 1'b1;
                vsel_s     = (cmd_s == CMD_MOVI);
            end
            S_ERR: begin
                done_s = 1'b1;
                err_s  = 1'b1;
            end
            default: ready_s = 1'b0;
        endcase
    end

    // State and captured-field registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            cmd_r   <= '0;
            rd_r    <= 3'd0;
            rn_r    <= 3'd0;
            rm_r    <= 3'd0;
            shift_r <= 2'd0;
            imm_r   <= '0;
        end else begin
            state_r <= state_s;
            cmd_r   <= cmd_s;
            rd_r    <= rd_s;
            rn_r    <= rn_s;
            rm_r    <= rm_s;
            shift_r <= shift_s;
            imm_r   <= imm_s;
        end
    end

    // Output registers; reset drops every strobe at once, aborting any command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r     <= 1'b1;
            readnum_r   <= 3'd0;
            writenum_r  <= 3'd0;
            rf_write_r  <= 1'b0;
            loada_r     <= 1'b0;
            loadb_r     <= 1'b0;
            loadc_r     <= 1'b0;
            loads_r     <= 1'b0;
            asel_r      <= 1'b0;
            vsel_r      <= 1'b0;
            alu_op_r    <= 2'b00;
            shift_out_r <= 2'b00;
            imm16_r     <= 16'h0000;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ready_r     <= ready_s;
            readnum_r   <= readnum_s;
            writenum_r  <= writenum_s;
            rf_write_r  <= rf_write_s;
            loada_r     <= loada_s;
            loadb_r     <= loadb_s;
            loadc_r     <= loadc_s;
            loads_r     <= loads_s;
            asel_r      <= asel_s;
            vsel_r      <= vsel_s;
            alu_op_r    <= alu_op_s;
            shift_out_r <= shift_out_s;
            imm16_r     <= imm_ext(imm_s);
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign instr_ready = ready_r;
    assign rf_readnum  = readnum_r;
    assign rf_writenum = writenum_r;
    assign rf_write    = rf_write_r;
    assign loada       = loada_r;
    assign loadb       = loadb_r;
    assign loadc       = loadc_r;
    assign loads       = loads_r;
    assign asel        = asel_r;
    assign vsel        = vsel_r;
    assign alu_op      = alu_op_r;
    assign shift_out   = shift_out_r;
    assign imm16       = imm16_r;
    assign done        = done_r;
    assign err         = err_r;

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_r;

    // Retired-command counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_r <= 16'h0000;
        end else if (done_r) begin
            perf_r <= perf_r + 16'h0001;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_retired = perf_r;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; the counter scenario is
// compiled only when ALU_SEQ_PERF_EN is defined.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  cmd = 3'd0;
    logic [2:0]  rd = 3'd0, rn = 3'd0, rm = 3'd0;
    logic [1:0]  shift = 2'd0;
    logic [7:0]  imm = 8'd0;
    logic [2:0]  rf_readnum, rf_writenum;
    logic        rf_write, loada, loadb, loadc, loads, asel, vsel, done, err;
    logic [1:0]  alu_op, shift_out;
    logic [15:0] imm16;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_retired;
`endif

    int checks = 0;
    int failures = 0;

    // strb: ready, rf_write, loada, loadb, loadc, loads, asel, vsel, done, err
    logic [9:0] strb;
    logic [9:0] nums;
    assign strb = {instr_ready, rf_write, loada, loadb, loadc, loads, asel, vsel, done, err};
    assign nums = {rf_readnum, rf_writenum, alu_op, shift_out};

    alu_sequencer #(.CMD_W(3), .IMM_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .cmd(cmd), .rd(rd), .rn(rn), .rm(rm), .shift(shift), .imm(imm),
        .rf_readnum(rf_readnum), .rf_writenum(rf_writenum), .rf_write(rf_write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .vsel(vsel), .alu_op(alu_op), .shift_out(shift_out),
        .imm16(imm16), .done(done), .err(err)
`ifdef ALU_SEQ_PERF_EN
        , .perf_retired(perf_retired)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [2:0] d, input logic [2:0] n,
                         input logic [2:0] m, input logic [1:0] s, input logic [7:0] i);
        cmd = c; rd = d; rn = n; rm = m; shift = s; imm = i;
        instr_valid = 1'b1;
    endtask

    task automatic test_reset();
        drive(3'd5, 3'd1, 3'd2, 3'd3, 2'd1, 8'hAA);
        #12;
        checks++;
        if ({strb, nums, imm16} !== {10'b1000000000, 10'd0, 16'h0000}) begin
            failures++;
            $display("FAIL reset_vals strb=%b nums=%b imm16=%h want 1000000000 0 0000", strb, nums, imm16);
        end
        tick();
        tick();
        checks++;
        if ({strb, imm16} !== {10'b1000000000, 16'h0000}) begin
            failures++;
            $display("FAIL reset_no_accept strb=%b imm16=%h want 1000000000 0000", strb, imm16);
        end
        instr_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if (strb !== 10'b1000000000) begin
            failures++;
            $display("FAIL post_reset_idle strb=%b want 1000000000", strb);
        end
    endtask

    task automatic test_add();
        logic [9:0] es [5] = '{10'b0010000000, 10'b0001000000, 10'b0000100000,
                               10'b0100000010, 10'b1000000000};
        logic [9:0] en [5] = '{{3'd0, 3'd0, 2'b00, 2'b00}, {3'd1, 3'd0, 2'b00, 2'b00},
                               10'd0, {3'd0, 3'd2, 2'b00, 2'b00}, 10'd0};
        drive(3'd0, 3'd2, 3'd0, 3'd1, 2'd0, 8'h00);
        for (int c = 0; c < 5; c++) begin
            tick();
            instr_valid = 1'b0;
            checks++;
            if ({strb, nums} !== {es[c], en[c]}) begin
                failures++;
                $display("FAIL add cyc%0d strb=%b nums=%b want %b %b", c + 1, strb, nums, es[c], en[c]);
            end
        end
    endtask

    task automatic test_and();
        logic [9:0] es [4] = '{10'b0010000000, 10'b0001000000, 10'b0000100000, 10'b0100000010};
        logic [9:0] en [4] = '{{3'd7, 3'd0, 2'b00, 2'b00}, {3'd2, 3'd0, 2'b00, 2'b00},
                               {3'd0, 3'd0, 2'b10, 2'b10}, {3'd0, 3'd4, 2'b00, 2'b00}};
        drive(3'd2, 3'd4, 3'd7, 3'd2, 2'd2, 8'h00);
        for (int c = 0; c < 4; c++) begin
            tick();
            instr_valid = 1'b0;
            checks++;
            if ({strb, nums} !== {es[c], en[c]}) begin
                failures++;
                $display("FAIL and cyc%0d strb=%b nums=%b want %b %b", c + 1, strb, nums, es[c], en[c]);
            end
        end
        tick();
    endtask

    task automatic test_cmp();
        logic [9:0] es [4] = '{10'b0010000000, 10'b0001000000, 10'b0000010010, 10'b1000000000};
        logic [9:0] en [4] = '{{3'd3, 3'd0, 2'b00, 2'b00}, {3'd4, 3'd0, 2'b00, 2'b00},
                               {3'd0, 3'd0, 2'b01, 2'b10}, 10'd0};
        drive(3'd1, 3'd7, 3'd3, 3'd4, 2'd2, 8'h00);
        for (int c = 0; c < 4; c++) begin
            tick();
            instr_valid = 1'b0;
            checks++;
            if ({strb, nums} !== {es[c], en[c]}) begin
                failures++;
                $display("FAIL cmp cyc%0d strb=%b nums=%b want %b %b", c + 1, strb, nums, es[c], en[c]);
            end
        end
    endtask

    task automatic test_movi();
        logic [7:0]  iv [2] = '{8'h80, 8'h7F};
        logic [2:0]  dv [2] = '{3'd5, 3'd1};
        logic [15:0] ev [2] = '{16'hFF80, 16'h007F};
        for (int k = 0; k < 2; k++) begin
            drive(3'd5, dv[k], 3'd6, 3'd6, 2'd3, iv[k]);
            tick();
            instr_valid = 1'b0;
            checks++;
            if ({strb, nums, imm16} !== {10'b0100000110, 3'd0, dv[k], 4'd0, ev[k]}) begin
                failures++;
                $display("FAIL movi%0d strb=%b nums=%b imm16=%h want 0100000110 %b %h",
                         k, strb, nums, imm16, {3'd0, dv[k], 4'd0}, ev[k]);
            end
            tick();
            checks++;
            if (strb !== 10'b1000000000) begin
                failures++;
                $display("FAIL movi%0d_idle strb=%b want 1000000000", k, strb);
            end
        end
    endtask

    task automatic test_mvn_movr();
        logic [2:0] cv [2] = '{3'd3, 3'd4};
        logic [9:0] es [2][4] = '{'{10'b0001000000, 10'b0000100000, 10'b0100000010, 10'b1000000000},
                                  '{10'b0001000000, 10'b0000101000, 10'b0100000010, 10'b1000000000}};
        logic [9:0] en [2][4] = '{'{{3'd6, 3'd0, 2'b00, 2'b00}, {3'd0, 3'd0, 2'b11, 2'b01},
                                    {3'd0, 3'd3, 2'b00, 2'b00}, 10'd0},
                                  '{{3'd5, 3'd0, 2'b00, 2'b00}, {3'd0, 3'd0, 2'b00, 2'b11},
                                    {3'd0, 3'd1, 2'b00, 2'b00}, 10'd0}};
        drive(3'd3, 3'd3, 3'd2, 3'd6, 2'd1, 8'h00);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) drive(3'd4, 3'd1, 3'd7, 3'd5, 2'd3, 8'h00);
            for (int c = 0; c < 4; c++) begin
                tick();
                instr_valid = 1'b0;
                checks++;
                if ({strb, nums} !== {es[k][c], en[k][c]}) begin
                    failures++;
                    $display("FAIL cmd%0d cyc%0d strb=%b nums=%b want %b %b",
                             cv[k], c + 1, strb, nums, es[k][c], en[k][c]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] cv [2] = '{3'd7, 3'd6};
        for (int k = 0; k < 2; k++) begin
            drive(cv[k], 3'd7, 3'd7, 3'd7, 2'd3, 8'hFF);
            tick();
            instr_valid = 1'b0;
            checks++;
            if ({strb, nums} !== {10'b0000000011, 10'd0}) begin
                failures++;
                $display("FAIL illegal%0d strb=%b nums=%b want 0000000011 0", cv[k], strb, nums);
            end
            tick();
            checks++;
            if (strb !== 10'b1000000000) begin
                failures++;
                $display("FAIL illegal%0d_idle strb=%b want 1000000000", cv[k], strb);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  es [7] = '{10'b0010000000, 10'b0001000000, 10'b0000100000, 10'b0100000010,
                                10'b1000000000, 10'b0100000110, 10'b1000000000};
        logic [9:0]  en [7] = '{{3'd1, 3'd0, 2'b00, 2'b00}, {3'd2, 3'd0, 2'b00, 2'b00}, 10'd0,
                                {3'd0, 3'd6, 2'b00, 2'b00}, 10'd0, {3'd0, 3'd3, 2'b00, 2'b00}, 10'd0};
        logic [15:0] ei [7] = '{16'h0012, 16'h0012, 16'h0012, 16'h0012, 16'h0012, 16'hFFF0, 16'hFFF0};
        drive(3'd0, 3'd6, 3'd1, 3'd2, 2'd0, 8'h12);
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 0) drive(3'd5, 3'd3, 3'd4, 3'd4, 2'd1, 8'hF0);
            if (c == 5) instr_valid = 1'b0;
            checks++;
            if ({strb, nums, imm16} !== {es[c], en[c], ei[c]}) begin
                failures++;
                $display("FAIL b2b cyc%0d strb=%b nums=%b imm16=%h want %b %b %h",
                         c + 1, strb, nums, imm16, es[c], en[c], ei[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(3'd0, 3'd2, 3'd0, 3'd1, 2'd0, 8'h33);
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (strb !== 10'b0000100000) begin
            failures++;
            $display("FAIL rst_mid_exec strb=%b want 0000100000", strb);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({strb, nums, imm16} !== {10'b1000000000, 10'd0, 16'h0000}) begin
            failures++;
            $display("FAIL rst_mid_abort strb=%b nums=%b imm16=%h want 1000000000 0 0000", strb, nums, imm16);
        end
        tick();
        #2 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (strb !== 10'b1000000000) begin
                failures++;
                $display("FAIL rst_mid_after%0d strb=%b want 1000000000", c, strb);
            end
        end
    endtask

`ifdef ALU_SEQ_PERF_EN
    task automatic test_perf_wrap();
        int cnt = 0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (perf_retired !== 16'h0000) begin
            failures++;
            $display("FAIL perf_reset got=%h want 0000", perf_retired);
        end
        tick();
        reset_n = 1'b1;
        drive(3'd7, 3'd0, 3'd0, 3'd0, 2'd0, 8'h00);
        for (int k = 0; k < 140000 && cnt < 65535; k++) begin
            tick();
            if (done) cnt++;
        end
        instr_valid = 1'b0;
        tick();
        checks++;
        if (cnt != 65535 || perf_retired !== 16'hFFFF) begin
            failures++;
            $display("FAIL perf_preload cnt=%0d perf=%h want 65535 FFFF", cnt, perf_retired);
        end
        drive(3'd5, 3'd5, 3'd0, 3'd0, 2'd0, 8'h01);
        tick();
        instr_valid = 1'b0;
        checks++;
        if ({done, perf_retired} !== {1'b1, 16'hFFFF}) begin
            failures++;
            $display("FAIL perf_pre_wrap done=%b perf=%h want 1 FFFF", done, perf_retired);
        end
        tick();
        checks++;
        if (perf_retired !== 16'h0000) begin
            failures++;
            $display("FAIL perf_wrap got=%h want 0000", perf_retired);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_cmp();
        test_and();
        test_movi();
        test_mvn_movr();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_SEQ_PERF_EN
        test_perf_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
